piso_serial_tx: RTL and testbench



---
 rtl/piso_serial_tx_pkg.sv | 30 +++
 rtl/piso_serial_tx_bit_timer.sv | 48 ++++
 rtl/piso_serial_tx.sv | 146 ++++++++++++++
 tb/tb_piso_serial_tx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_serial_tx_pkg.sv
// Shared definitions for the piso_serial_tx framed transmitter.
// Contents:
//   state_e    - FSM state encoding (IDLE, START, DATA, STOP)
//   LINE_IDLE  - level of the serial line between frames
//   START_BIT  - level of the start bit
//   STOP_BIT   - level of the stop bit
//   cnt_width  - counter width helper, max(1, clog2(n))
package piso_serial_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // A counter that must hold 0..n-1 never needs fewer than one bit.
    function automatic int cnt_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/piso_serial_tx_bit_timer.sv
// Bit-period timer for piso_serial_tx.
// Counts 0..CLKS_PER_BIT-1 and wraps, flagging the last cycle of each bit.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset
//   clear - holds the count at zero so the next period starts fresh
//   tick  - high on the last cycle of each bit period
module piso_serial_tx_bit_timer
    import piso_serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // With CLKS_PER_BIT=1 LAST is zero, so every cycle is a tick.
    assign tick = (cnt_q == LAST);

    // Next count: restart on clear or at the end of a bit period.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + ONE;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in, serial-out framed transmitter.
// Sends start bit (0), DATA_W data bits LSB first, stop bit (1), each held
// for CLKS_PER_BIT clocks. All outputs come straight from flops.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset, aborts any frame in progress
//   load  - producer request; word taken on an edge where load && ready
//   din   - parallel word, sampled only at acceptance
//   ready - high in IDLE, a word can be accepted
//   sdout - serial line, idles high
//   busy  - high while a frame is on the line (always !ready)
//   done  - one-cycle pulse in the first IDLE cycle after a stop bit
module piso_serial_tx
    import piso_serial_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    output logic              ready,
    output logic              sdout,
    output logic              busy,
    output logic              done
);

    localparam int            BW       = cnt_width(DATA_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
    localparam logic [BW-1:0] ONE_BIT  = BW'(1);

    state_e            state_q;
    state_e            state_d;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [BW-1:0]     bit_cnt_q;
    logic [BW-1:0]     bit_cnt_d;
    logic              sdout_q;
    logic              sdout_d;
    logic              ready_q;
    logic              ready_d;
    logic              done_q;
    logic              done_d;
    logic              tick_s;
    logic              timer_clear_s;

    // Holding the timer in IDLE makes the start bit begin a full period.
    assign timer_clear_s = (state_q == ST_IDLE);

    piso_serial_tx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .reset (reset),
        .clear (timer_clear_s),
        .tick  (tick_s)
    );

    // Next-state logic for the frame FSM, shift register and bit counter.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    shift_d = din;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + ONE_BIT;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values are derived from the next state so they can be registered
    // and line up exactly with the state they belong to.
    always_comb begin
        case (state_d)
            ST_START: sdout_d = START_BIT;
            ST_DATA:  sdout_d = shift_d[0];
            ST_STOP:  sdout_d = STOP_BIT;
            default:  sdout_d = LINE_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset abandons any frame without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            sdout_q   <= LINE_IDLE;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            sdout_q   <= sdout_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
    end

    assign ready = ready_q;
    assign busy  = ~ready_q;
    assign sdout = sdout_q;
    assign done  = done_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
module tb_piso_serial_tx;

    localparam int DW    = 8;
    localparam int CPB   = 4;
    localparam int FRAME = (DW + 2) * CPB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          load;
    logic [DW-1:0] din;
    logic          ready;
    logic          sdout;
    logic          busy;
    logic          done;

    logic          c_reset;
    logic          c_load;
    logic [0:0]    c_din;
    logic          c_ready;
    logic          c_sdout;
    logic          c_busy;
    logic          c_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    piso_serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .din   (din),
        .ready (ready),
        .sdout (sdout),
        .busy  (busy),
        .done  (done)
    );

    piso_serial_tx #(.DATA_W(1), .CLKS_PER_BIT(1)) dut_c (
        .clk   (clk),
        .reset (c_reset),
        .load  (c_load),
        .din   (c_din),
        .ready (c_ready),
        .sdout (c_sdout),
        .busy  (c_busy),
        .done  (c_done)
    );

    // Reference line level k cycles after the accepting edge (k = 0 is the
    // first cycle of the frame): bit slot k/cpb is start, data[LSB..], stop.
    function automatic logic exp_bit(input logic [31:0] word, input int k,
                                     input int dw, input int cpb);
        int idx;
        idx = k / cpb;
        if (idx == 0) return 1'b0;
        else if (idx <= dw) return word[idx-1];
        else return 1'b1;
    endfunction

    // Called at the negedge where load/din for the accepting edge were set.
    // Checks every frame cycle plus the done cycle, then sets up chaining.
    task automatic expect_frame(input logic [DW-1:0] word, input int intrude_k,
                                input bit chain, input logic [DW-1:0] next_word,
                                input string name);
        logic [3:0] exp_s;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            load  = (k == intrude_k);
            din   = (k == intrude_k) ? 8'hFF : 8'($urandom);
            exp_s = {exp_bit({24'h0, word}, k, DW, CPB), 1'b1, 1'b0, 1'b0};
            checks++;
            if ({sdout, busy, ready, done} !== exp_s) begin
                errors++;
                $display("FAIL %s cycle %0d word %h: sdout/busy/ready/done got %b expected %b",
                         name, k + 1, word, {sdout, busy, ready, done}, exp_s);
            end
        end
        @(negedge clk);
        checks++;
        if ({sdout, busy, ready, done} !== 4'b1011) begin
            errors++;
            $display("FAIL %s done_cycle word %h: sdout/busy/ready/done got %b expected 1011",
                     name, word, {sdout, busy, ready, done});
        end
        load = chain;
        din  = next_word;
    endtask

    task automatic expect_idle(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if ({sdout, busy, ready, done} !== 4'b1010) begin
                errors++;
                $display("FAIL %s idle cycle %0d: sdout/busy/ready/done got %b expected 1010",
                         name, i, {sdout, busy, ready, done});
            end
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        load    = 1'b1;
        din     = 8'($urandom);
        c_reset = 1'b1;
        c_load  = 1'b1;
        c_din   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({sdout, busy, ready, done} !== 4'b1010) begin
                errors++;
                $display("FAIL reset cycle %0d: sdout/busy/ready/done got %b expected 1010",
                         i, {sdout, busy, ready, done});
            end
            checks++;
            if ({c_sdout, c_busy, c_ready, c_done} !== 4'b1010) begin
                errors++;
                $display("FAIL reset_corner cycle %0d: sdout/busy/ready/done got %b expected 1010",
                         i, {c_sdout, c_busy, c_ready, c_done});
            end
        end
        reset   = 1'b0;
        load    = 1'b0;
        c_reset = 1'b0;
        c_load  = 1'b0;
        expect_idle(3, "reset_no_accept");
    endtask

    task automatic test_single();
        @(negedge clk);
        load = 1'b1;
        din  = 8'hA5;
        expect_frame(8'hA5, -1, 1'b0, 8'h00, "single_a5");
        expect_idle(2, "single_after");
    endtask

    task automatic test_busy_reject();
        @(negedge clk);
        load = 1'b1;
        din  = 8'h3C;
        expect_frame(8'h3C, 9, 1'b0, 8'h00, "busy_reject");
        expect_idle(6, "busy_reject_after");
    endtask

    task automatic test_back_to_back();
        int t1;
        int t2;
        @(negedge clk);
        load = 1'b1;
        din  = 8'h01;
        t1   = cyc;
        expect_frame(8'h01, -1, 1'b1, 8'h80, "b2b_first");
        t2 = cyc;
        expect_frame(8'h80, -1, 1'b0, 8'h00, "b2b_second");
        checks++;
        if (t2 - t1 !== 41) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles expected 41", t2 - t1);
        end
        expect_idle(2, "b2b_after");
    endtask

    task automatic test_mid_reset();
        logic [DW-1:0] w;
        logic [3:0]    exp_s;
        w = 8'($urandom);
        @(negedge clk);
        load = 1'b1;
        din  = w;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            load  = 1'b0;
            exp_s = {exp_bit({24'h0, w}, k, DW, CPB), 1'b1, 1'b0, 1'b0};
            checks++;
            if ({sdout, busy, ready, done} !== exp_s) begin
                errors++;
                $display("FAIL mid_reset_pre cycle %0d: got %b expected %b",
                         k + 1, {sdout, busy, ready, done}, exp_s);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({sdout, busy, ready, done} !== 4'b1010) begin
            errors++;
            $display("FAIL mid_reset_edge: sdout/busy/ready/done got %b expected 1010",
                     {sdout, busy, ready, done});
        end
        reset = 1'b0;
        expect_idle(50, "mid_reset_no_done");
        @(negedge clk);
        load = 1'b1;
        din  = 8'h55;
        expect_frame(8'h55, -1, 1'b0, 8'h00, "after_reset_55");
        expect_idle(1, "after_reset_idle");
    endtask

    task automatic test_random_frames();
        logic [DW-1:0] w;
        for (int n = 0; n < 6; n++) begin
            w = 8'($urandom);
            @(negedge clk);
            load = 1'b1;
            din  = w;
            expect_frame(w, -1, 1'b0, 8'h00, "random");
            expect_idle($urandom_range(3, 1), "random_gap");
        end
    endtask

    task automatic test_corner();
        logic [3:0] exp_s;
        logic [3:0] got_s;
        for (int d = 1; d >= 0; d--) begin
            @(negedge clk);
            c_load = 1'b1;
            c_din  = 1'(d);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                c_load = 1'b0;
                c_din  = 1'($urandom);
                exp_s  = {exp_bit(32'(d), k, 1, 1), 1'b1, 1'b0, 1'b0};
                got_s  = {c_sdout, c_busy, c_ready, c_done};
                checks++;
                if (got_s !== exp_s) begin
                    errors++;
                    $display("FAIL corner din=%0d cycle %0d: got %b expected %b",
                             d, k + 1, got_s, exp_s);
                end
            end
            @(negedge clk);
            got_s = {c_sdout, c_busy, c_ready, c_done};
            checks++;
            if (got_s !== 4'b1011) begin
                errors++;
                $display("FAIL corner_done din=%0d cycle 4: got %b expected 1011", d, got_s);
            end
            @(negedge clk);
            got_s = {c_sdout, c_busy, c_ready, c_done};
            checks++;
            if (got_s !== 4'b1010) begin
                errors++;
                $display("FAIL corner_idle din=%0d: got %b expected 1010", d, got_s);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_busy_reject();
        test_back_to_back();
        test_mid_reset();
        test_random_frames();
        test_corner();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
